serial_addsub: RTL and testbench
================================

# serial_addsub

Parametrised bit-serial adder/subtractor built around one half-adder pair and a carry flop. It processes a WIDTH-bit operand pair one bit per clock, LSB first. A start/busy/done handshake frames each operation. It is the area-minimal arithmetic unit for control-path datapaths where latency is acceptable and a WIDTH-bit parallel adder is not.

## Interface
- WIDTH, 8, operand/result width in bits; legal range 2..64.
- clk  input  1  rising-edge clock; sole clock domain.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled on clk rising edge; accepted only in IDLE or DONE.
- sub  input  1  mode, sampled with start: 0 = a+b, 1 = a-b.
- a  input  WIDTH  operand A, sampled with accepted start.
- b  input  WIDTH  operand B, sampled with accepted start.
- busy  output  1  high while bits are being processed.
- done  output  1  one-cycle pulse; result outputs valid and updated.
- sum  output  WIDTH  result register, two's-complement wrap modulo 2^WIDTH.
- carry_out  output  1  final carry; in subtract mode 1 = no borrow (a >= b unsigned).
- overflow  output  1  signed overflow: carry into MSB XOR carry out of MSB.

## Operation
- States: IDLE, BUSY, DONE.
- IDLE or DONE with start=1:
  - Load shift register A <= a.
  - Load shift register B <= (sub ? ~b : b).
  - Load carry <= sub.
  - Clear bit counter to 0 and go to BUSY.
- IDLE with start=0: stay in IDLE.
- DONE with start=0: go to IDLE.
- BUSY, each edge:
  - s = A[0] ^ B[0] ^ carry (two cascaded half adders).
  - carry <= (A[0]&B[0]) | (carry&(A[0]^B[0])).
  - s shifts into the MSB of the internal result shift register; A and B shift right.
  - Counter increments.
- On the edge that processes bit WIDTH-1:
  - Result shift register value goes to sum; final carry goes to carry_out.
  - overflow <= carry-in of bit WIDTH-1 XOR final carry.
  - State goes to DONE.
- start while BUSY is ignored; it is not queued and a, b and sub are not sampled.
- sum, carry_out and overflow change only on the completion edge or on reset. They hold between operations.
- The counter is $clog2(WIDTH) bits wide and never wraps past WIDTH-1.

## Timing
- Reset (rst_n low, asynchronous):
  - State is IDLE.
  - busy=0, done=0, sum=0, carry_out=0, overflow=0.
  - Internal shift registers, carry and counter are cleared.
- Reset mid-operation aborts the operation immediately. There is no done pulse, and outputs return to reset values.
- Deassertion of reset is taken synchronously. The first start can be accepted on the first clk edge with rst_n high.
- Start accepted at edge E0:
  - busy=1 from E0 through E0+WIDTH-1.
  - At edge E0+WIDTH: busy=0, done=1, results valid.
  - At edge E0+WIDTH+1: done=0, unless a new start was accepted.
- Latency is WIDTH cycles from the accepting edge to done.
- Throughput: back-to-back operations are supported.
  - A start held high in DONE is accepted at E0+WIDTH+1, so busy rises again in the cycle after done.
  - This gives one operation per WIDTH+1 cycles.
- busy and done are never high in the same cycle.

## Test plan
- WIDTH=8, add 0x5A+0x3C -> done exactly 8 edges after the start edge; sum=0x96, carry_out=0, overflow=1.
- Add 0xFF+0x01 -> sum=0x00, carry_out=1, overflow=0. Add 0x00+0x00 -> sum=0x00, carry_out=0, overflow=0.
- Subtract 0x10-0x20 -> sum=0xF0, carry_out=0, overflow=0. Subtract 0x80-0x01 -> sum=0x7F, carry_out=1, overflow=1.
- Pulse start with new a, b and sub on edges 3 and 5 of a BUSY operation -> ignored; the original operation's result is produced on schedule.
- Hold start high with a new operand pair in the DONE cycle -> busy rises the next cycle; the second result appears WIDTH edges later. The first result holds until then.
- Assert rst_n low mid-BUSY (after 4 bits) -> outputs zero immediately and no done pulse. After release, a fresh start gives a correct result. Repeat for WIDTH=2 and WIDTH=32 with random operands checked against a reference model.

Source files
------------

// File: rtl/serial_addsub_if.sv
// Handshake and operand/result bundle for the bit-serial adder/subtractor.
// The master side issues start/sub/a/b; the slave side returns status and results.
interface serial_addsub_if #(
   parameter int WIDTH = 8
) ();
   logic             start;
   logic             sub;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] sum;
   logic             carry_out;
   logic             overflow;

   modport master (
      output start, sub, a, b,
      input  busy, done, sum, carry_out, overflow
   );

   modport slave (
      input  start, sub, a, b,
      output busy, done, sum, carry_out, overflow
   );
endinterface

// File: rtl/serial_addsub.sv
// Bit-serial WIDTH-bit adder/subtractor: one bit per clock, LSB first, framed by a
// start/busy/done handshake. Subtraction is a + ~b + 1 using the carry flop as the +1.
module serial_addsub #(
   parameter int WIDTH = 8
) (
   input logic          clk,
   input logic          rst_n,
   serial_addsub_if.slave bus
);

   localparam int            CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t           state;
   logic [WIDTH-1:0] sh_a;
   logic [WIDTH-1:0] sh_b;
   logic [WIDTH-2:0] sh_r;
   logic [WIDTH-1:0] sum_q;
   logic [CW-1:0]    cnt;
   logic             carry;
   logic             carry_out_q;
   logic             overflow_q;
   logic             busy_q;
   logic             done_q;

   logic             prop;
   logic             gen;
   logic             s_bit;
   logic             c_next;
   logic [WIDTH-1:0] r_next;

   // Two cascaded half adders: first on the operand bits, second adds the carry.
   always_comb begin
      prop   = sh_a[0] ^ sh_b[0];
      gen    = sh_a[0] & sh_b[0];
      s_bit  = prop ^ carry;
      c_next = gen | (carry & prop);
      r_next = {s_bit, sh_r};
   end

   // NOTE: every register here is plain state (no memory arrays), so all of it is
   // cleared by the async reset and updated only with non-blocking assignments.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         sh_a        <= '0;
         sh_b        <= '0;
         sh_r        <= '0;
         sum_q       <= '0;
         cnt         <= '0;
         carry       <= 1'b0;
         carry_out_q <= 1'b0;
         overflow_q  <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         case (state)
            IDLE, DONE: begin
               done_q <= 1'b0;
               if (bus.start) begin
                  sh_a   <= bus.a;
                  sh_b   <= bus.sub ? ~bus.b : bus.b;
                  sh_r   <= '0;
                  carry  <= bus.sub;
                  cnt    <= '0;
                  busy_q <= 1'b1;
                  state  <= BUSY;
               end else begin
                  busy_q <= 1'b0;
                  state  <= IDLE;
               end
            end
            BUSY: begin
               sh_a  <= sh_a >> 1;
               sh_b  <= sh_b >> 1;
               sh_r  <= r_next[WIDTH-1:1];
               carry <= c_next;
               if (cnt == LAST) begin
                  // carry still holds the carry into the MSB at this point.
                  sum_q       <= r_next;
                  carry_out_q <= c_next;
                  overflow_q  <= carry ^ c_next;
                  busy_q      <= 1'b0;
                  done_q      <= 1'b1;
                  state       <= DONE;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: begin
               busy_q <= 1'b0;
               done_q <= 1'b0;
               state  <= IDLE;
            end
         endcase
      end
   end

   assign bus.busy      = busy_q;
   assign bus.done      = done_q;
   assign bus.sum       = sum_q;
   assign bus.carry_out = carry_out_q;
   assign bus.overflow  = overflow_q;

endmodule

// File: tb/tb_serial_addsub.sv
// Directed bench for serial_addsub at WIDTH=8, plus reference-model checks at WIDTH=2 and 32.
module tb_serial_addsub;

   logic clk;
   logic rst_n;
   int   n_cmp;
   int   n_err;
   logic [7:0] last8;

   serial_addsub_if #(.WIDTH(8))  b8  ();
   serial_addsub_if #(.WIDTH(2))  b2  ();
   serial_addsub_if #(.WIDTH(32)) b32 ();

   serial_addsub #(.WIDTH(8))  u8  (.clk(clk), .rst_n(rst_n), .bus(b8));
   serial_addsub #(.WIDTH(2))  u2  (.clk(clk), .rst_n(rst_n), .bus(b2));
   serial_addsub #(.WIDTH(32)) u32 (.clk(clk), .rst_n(rst_n), .bus(b32));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: observed timeout expected summary");
      $fatal(1, "watchdog expired");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic launch8(logic s, logic [7:0] a, logic [7:0] b);
      b8.start = 1'b1;
      b8.sub   = s;
      b8.a     = a;
      b8.b     = b;
      tick();
      b8.start = 1'b0;
   endtask

   // Called just after the accepting edge. With noise set, a conflicting start is
   // pulsed on BUSY edges 3 and 5; it must have no effect.
   task automatic run8(string tag, logic noise, logic [7:0] es, logic eco, logic eov);
      for (int i = 0; i < 8; i++) begin
         check({tag, ".busy"}, 64'(b8.busy), 64'd1);
         check({tag, ".nodone"}, 64'(b8.done), 64'd0);
         check({tag, ".hold"}, 64'(b8.sum), 64'(last8));
         if (noise && (i == 2 || i == 4)) begin
            b8.start = 1'b1;
            b8.sub   = 1'b1;
            b8.a     = 8'hFF;
            b8.b     = 8'h01;
         end
         tick();
         b8.start = 1'b0;
      end
      check({tag, ".done"}, 64'(b8.done), 64'd1);
      check({tag, ".busy_lo"}, 64'(b8.busy), 64'd0);
      check({tag, ".sum"}, 64'(b8.sum), 64'(es));
      check({tag, ".cout"}, 64'(b8.carry_out), 64'(eco));
      check({tag, ".ovf"}, 64'(b8.overflow), 64'(eov));
      last8 = es;
   endtask

   task automatic idle8(string tag);
      tick();
      check({tag, ".pulse_end"}, 64'(b8.done), 64'd0);
      check({tag, ".idle"}, 64'(b8.busy), 64'd0);
      check({tag, ".keep"}, 64'(b8.sum), 64'(last8));
   endtask

   // Reference: {overflow, carry_out, sum} from a full-width add of a + (b or ~b) + sub.
   function automatic logic [65:0] model(int w, logic s, logic [63:0] a, logic [63:0] b);
      logic [63:0] mask, am, bb, sm;
      logic [64:0] full;
      logic        ov;
      mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
      am   = a & mask;
      bb   = (s ? ~b : b) & mask;
      full = {1'b0, am} + {1'b0, bb} + 65'(s);
      sm   = full[63:0] & mask;
      ov   = (am[w-1] == bb[w-1]) && (sm[w-1] != am[w-1]);
      return {ov, full[w], sm};
   endfunction

   task automatic launch_w(int w, logic s, logic [63:0] a, logic [63:0] b);
      if (w == 2) begin
         b2.start = 1'b1; b2.sub = s; b2.a = a[1:0]; b2.b = b[1:0];
      end else begin
         b32.start = 1'b1; b32.sub = s; b32.a = a[31:0]; b32.b = b[31:0];
      end
      tick();
      b2.start  = 1'b0;
      b32.start = 1'b0;
   endtask

   task automatic run_w(string tag, int w, logic s, logic [63:0] a, logic [63:0] b);
      logic [65:0] exp;
      exp = model(w, s, a, b);
      for (int i = 0; i < w; i++) begin
         check({tag, ".busy"}, 64'((w == 2) ? b2.busy : b32.busy), 64'd1);
         tick();
      end
      check({tag, ".done"}, 64'((w == 2) ? b2.done : b32.done), 64'd1);
      check({tag, ".sum"}, (w == 2) ? 64'(b2.sum) : 64'(b32.sum), exp[63:0]);
      check({tag, ".cout"}, 64'((w == 2) ? b2.carry_out : b32.carry_out), 64'(exp[64]));
      check({tag, ".ovf"}, 64'((w == 2) ? b2.overflow : b32.overflow), 64'(exp[65]));
      tick();
      check({tag, ".pulse_end"}, 64'((w == 2) ? b2.done : b32.done), 64'd0);
   endtask

   initial begin
      logic [63:0] ra, rb;
      logic        rs;
      n_cmp = 0;
      n_err = 0;
      last8 = 8'h00;
      b8.start = 0;  b8.sub = 0;  b8.a = '0;  b8.b = '0;
      b2.start = 0;  b2.sub = 0;  b2.a = '0;  b2.b = '0;
      b32.start = 0; b32.sub = 0; b32.a = '0; b32.b = '0;
      rst_n = 1'b0;
      #1;
      check("rst.busy", 64'(b8.busy), 64'd0);
      check("rst.done", 64'(b8.done), 64'd0);
      check("rst.sum", 64'(b8.sum), 64'd0);
      check("rst.cout", 64'(b8.carry_out), 64'd0);
      check("rst.ovf", 64'(b8.overflow), 64'd0);
      tick();
      tick();
      rst_n = 1'b1;

      // Basic add/subtract vectors, each exactly 8 edges from start to done.
      launch8(1'b0, 8'h5A, 8'h3C); run8("add_5a_3c", 1'b0, 8'h96, 1'b0, 1'b1); idle8("add_5a_3c");
      launch8(1'b0, 8'hFF, 8'h01); run8("add_ff_01", 1'b0, 8'h00, 1'b1, 1'b0); idle8("add_ff_01");
      launch8(1'b0, 8'h00, 8'h00); run8("add_00_00", 1'b0, 8'h00, 1'b0, 1'b0); idle8("add_00_00");
      launch8(1'b1, 8'h10, 8'h20); run8("sub_10_20", 1'b0, 8'hF0, 1'b0, 1'b0); idle8("sub_10_20");
      launch8(1'b1, 8'h80, 8'h01); run8("sub_80_01", 1'b0, 8'h7F, 1'b1, 1'b1); idle8("sub_80_01");

      // Start pulses while busy are ignored.
      launch8(1'b0, 8'h12, 8'h34); run8("ignore", 1'b1, 8'h46, 1'b0, 1'b0); idle8("ignore");

      // Back-to-back: start held in the DONE cycle.
      launch8(1'b0, 8'h70, 8'h20); run8("b2b_first", 1'b0, 8'h90, 1'b0, 1'b1);
      launch8(1'b1, 8'h05, 8'h07);
      run8("b2b_second", 1'b0, 8'hFE, 1'b0, 1'b0); idle8("b2b_second");

      // Reset after 4 processed bits aborts the operation.
      launch8(1'b0, 8'hAA, 8'h11);
      for (int i = 0; i < 4; i++) tick();
      check("abort.busy_pre", 64'(b8.busy), 64'd1);
      rst_n = 1'b0;
      #1;
      check("abort.busy", 64'(b8.busy), 64'd0);
      check("abort.sum", 64'(b8.sum), 64'd0);
      check("abort.cout", 64'(b8.carry_out), 64'd0);
      check("abort.ovf", 64'(b8.overflow), 64'd0);
      tick();
      check("abort.nodone", 64'(b8.done), 64'd0);
      rst_n = 1'b1;
      last8 = 8'h00;
      launch8(1'b1, 8'h33, 8'h11); run8("post_rst", 1'b0, 8'h22, 1'b1, 1'b0); idle8("post_rst");

      // Narrow and wide instances against the reference model.
      for (int k = 0; k < 12; k++) begin
         rs = 1'($urandom_range(1));
         ra = 64'($urandom);
         rb = 64'($urandom);
         launch_w(2, rs, ra, rb);
         run_w("w2", 2, rs, ra, rb);
      end
      for (int k = 0; k < 6; k++) begin
         rs = 1'($urandom_range(1));
         ra = 64'($urandom);
         rb = 64'($urandom);
         launch_w(32, rs, ra, rb);
         run_w("w32", 32, rs, ra, rb);
      end

      // Abort at both extra widths, then a fresh operation.
      launch_w(32, 1'b0, 64'h1234_5678, 64'h0FED_CBA9);
      launch_w(2, 1'b0, 64'd3, 64'd1);
      for (int i = 0; i < 3; i++) tick();
      rst_n = 1'b0;
      #1;
      check("w32_abort.busy", 64'(b32.busy), 64'd0);
      check("w32_abort.sum", 64'(b32.sum), 64'd0);
      check("w2_abort.sum", 64'(b2.sum), 64'd0);
      check("w2_abort.cout", 64'(b2.carry_out), 64'd0);
      tick();
      check("w32_abort.nodone", 64'(b32.done), 64'd0);
      rst_n = 1'b1;
      ra = 64'($urandom);
      rb = 64'($urandom);
      launch_w(32, 1'b1, ra, rb);
      run_w("w32_post_rst", 32, 1'b1, ra, rb);
      launch_w(2, 1'b1, 64'd1, 64'd2);
      run_w("w2_post_rst", 2, 1'b1, 64'd1, 64'd2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
